// File: rtl/mem_arb_2to1.sv
// rtl/mem_arb_2to1.sv - two-port round-robin memory request arbiter with ownership lock
//
// Purpose:
//   Merges an instruction-side port (s0) and a data-side port (s1) onto one
//   downstream memory port (m). An idle arbiter selects combinationally, so a
//   lone request or a tie adds no latency. Ties go to the port that did not
//   complete last. A request that is not granted in its first cycle locks
//   ownership to that port until it completes or the requestor withdraws.
//
// Ports:
//   g_clk, g_reset                       clock, asynchronous active-high reset
//   s0_req/addr/wen/strb/wdata           port 0 request and payload (in)
//   s0_gnt/err/rdata                     port 0 completion, error, read data (out)
//   s1_*                                 same as s0_* for port 1
//   m_req/addr/wen/strb/wdata            downstream request and payload (out)
//   m_gnt/err/rdata                      downstream completion, error, read data (in)

module mem_arb_2to1 #(
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_STRB_W = 8,
  parameter int MEM_DATA_W = 64
) (
  input  logic                  g_clk,
  input  logic                  g_reset,

  input  logic                  s0_req,
  input  logic [MEM_ADDR_W-1:0] s0_addr,
  input  logic                  s0_wen,
  input  logic [MEM_STRB_W-1:0] s0_strb,
  input  logic [MEM_DATA_W-1:0] s0_wdata,
  output logic                  s0_gnt,
  output logic                  s0_err,
  output logic [MEM_DATA_W-1:0] s0_rdata,

  input  logic                  s1_req,
  input  logic [MEM_ADDR_W-1:0] s1_addr,
  input  logic                  s1_wen,
  input  logic [MEM_STRB_W-1:0] s1_strb,
  input  logic [MEM_DATA_W-1:0] s1_wdata,
  output logic                  s1_gnt,
  output logic                  s1_err,
  output logic [MEM_DATA_W-1:0] s1_rdata,

  output logic                  m_req,
  output logic [MEM_ADDR_W-1:0] m_addr,
  output logic                  m_wen,
  output logic [MEM_STRB_W-1:0] m_strb,
  output logic [MEM_DATA_W-1:0] m_wdata,
  input  logic                  m_gnt,
  input  logic                  m_err,
  input  logic [MEM_DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   lsb, lsb_nxt;   // port that completed most recently
  logic   active;         // a selected port is presenting a live request
  logic   sel;            // selected port index
  logic   done;           // downstream completes the selected transaction

  // Port selection. In an owned state only the owner is considered, and a
  // withdrawn owner request leaves nothing selected (abort).
  always_comb begin
    active = 1'b0;
    sel    = 1'b0;
    case (state)
      OWN0: begin
        sel    = 1'b0;
        active = s0_req;
      end
      OWN1: begin
        sel    = 1'b1;
        active = s1_req;
      end
      default: begin
        if (s0_req && s1_req) begin
          active = 1'b1;
          sel    = ~lsb;
        end else if (s0_req) begin
          active = 1'b1;
          sel    = 1'b0;
        end else if (s1_req) begin
          active = 1'b1;
          sel    = 1'b1;
        end
      end
    endcase
    // Nothing leaves the arbiter while reset is held.
    if (g_reset) begin
      active = 1'b0;
    end
  end

  // Downstream drive: only the selected port's payload is ever forwarded,
  // everything is zero when no port is selected.
  always_comb begin
    m_req   = active;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    if (active) begin
      m_addr  = sel ? s1_addr  : s0_addr;
      m_wen   = sel ? s1_wen   : s0_wen;
      m_strb  = sel ? s1_strb  : s0_strb;
      m_wdata = sel ? s1_wdata : s0_wdata;
    end
  end

  // A downstream grant counts only against a live request, so stray m_gnt
  // or m_err never reach a requestor.
  assign done     = active && m_gnt;
  assign s0_gnt   = done && !sel;
  assign s1_gnt   = done && sel;
  assign s0_err   = s0_gnt && m_err;
  assign s1_err   = s1_gnt && m_err;
  assign s0_rdata = s0_gnt ? m_rdata : '0;
  assign s1_rdata = s1_gnt ? m_rdata : '0;

  always_comb begin
    state_nxt = state;
    lsb_nxt   = lsb;
    if (!active) begin
      state_nxt = IDLE;
    end else if (m_gnt) begin
      state_nxt = IDLE;
      lsb_nxt   = sel;
    end else begin
      state_nxt = sel ? OWN1 : OWN0;
    end
  end

  // lsb resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= IDLE;
      lsb   <= 1'b1;
    end else begin
      state <= state_nxt;
      lsb   <= lsb_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arb_2to1.sv
// tb/tb_mem_arb_2to1.sv - self-checking bench for mem_arb_2to1 against a behavioural model

module tb_mem_arb_2to1;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        s0_req, s0_wen, s0_gnt, s0_err;
  logic [63:0] s0_addr, s0_wdata, s0_rdata;
  logic [7:0]  s0_strb;
  logic        s1_req, s1_wen, s1_gnt, s1_err;
  logic [63:0] s1_addr, s1_wdata, s1_rdata;
  logic [7:0]  s1_strb;
  logic        m_req, m_wen, m_gnt, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_strb;

  int checks = 0;
  int errors = 0;

  // Reference model state: which port holds the lock (-1 none) and who completed last.
  int lock;
  int last;
  // Expected grants of the most recent step, and observed values for directed checks.
  bit e_g0, e_g1;
  logic obs_g0, obs_g1, obs_e0, obs_e1, obs_mreq;
  logic [63:0] obs_r1, obs_maddr;

  always #5 g_clk = ~g_clk;

  mem_arb_2to1 dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .s0_req   (s0_req),
    .s0_addr  (s0_addr),
    .s0_wen   (s0_wen),
    .s0_strb  (s0_strb),
    .s0_wdata (s0_wdata),
    .s0_gnt   (s0_gnt),
    .s0_err   (s0_err),
    .s0_rdata (s0_rdata),
    .s1_req   (s1_req),
    .s1_addr  (s1_addr),
    .s1_wen   (s1_wen),
    .s1_strb  (s1_strb),
    .s1_wdata (s1_wdata),
    .s1_gnt   (s1_gnt),
    .s1_err   (s1_err),
    .s1_rdata (s1_rdata),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_wen    (m_wen),
    .m_strb   (m_strb),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_err    (m_err),
    .m_rdata  (m_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs for this cycle are already driven (at a falling edge). Checks all
  // outputs against the model, advances the model across the next rising
  // edge, and returns at the following falling edge.
  task automatic step(input string tag);
    int who;
    bit fin;
    logic [63:0] x_addr, x_wdata;
    logic [7:0]  x_strb;
    logic        x_wen;
    #1;
    if (g_reset)                   who = -1;
    else if (lock == 0)            who = s0_req ? 0 : -1;
    else if (lock == 1)            who = s1_req ? 1 : -1;
    else if (s0_req && s1_req)     who = 1 - last;
    else if (s0_req)               who = 0;
    else if (s1_req)               who = 1;
    else                           who = -1;

    x_addr = '0; x_wdata = '0; x_strb = '0; x_wen = 1'b0;
    if (who == 0) begin x_addr = s0_addr; x_wdata = s0_wdata; x_strb = s0_strb; x_wen = s0_wen; end
    if (who == 1) begin x_addr = s1_addr; x_wdata = s1_wdata; x_strb = s1_strb; x_wen = s1_wen; end
    fin  = (who >= 0) && m_gnt;
    e_g0 = fin && who == 0;
    e_g1 = fin && who == 1;

    chk({tag, ".m_req"},   m_req,   (who >= 0));
    chk({tag, ".m_addr"},  m_addr,  x_addr);
    chk({tag, ".m_wen"},   m_wen,   x_wen);
    chk({tag, ".m_strb"},  m_strb,  x_strb);
    chk({tag, ".m_wdata"}, m_wdata, x_wdata);
    chk({tag, ".s0_gnt"},  s0_gnt,  e_g0);
    chk({tag, ".s0_err"},  s0_err,  e_g0 && m_err);
    chk({tag, ".s0_rdata"}, s0_rdata, e_g0 ? m_rdata : 64'd0);
    chk({tag, ".s1_gnt"},  s1_gnt,  e_g1);
    chk({tag, ".s1_err"},  s1_err,  e_g1 && m_err);
    chk({tag, ".s1_rdata"}, s1_rdata, e_g1 ? m_rdata : 64'd0);

    obs_g0 = s0_gnt; obs_g1 = s1_gnt; obs_e0 = s0_err; obs_e1 = s1_err;
    obs_mreq = m_req; obs_r1 = s1_rdata; obs_maddr = m_addr;

    if (g_reset) begin
      lock = -1;
      last = 1;
    end else if (who < 0) begin
      lock = -1;
    end else if (fin) begin
      last = who;
      lock = -1;
    end else begin
      lock = who;
    end
    @(negedge g_clk);
  endtask

  task automatic drive(input bit r0, input logic [63:0] a0, input bit r1, input logic [63:0] a1,
                       input bit g, input bit e, input logic [63:0] d);
    s0_req = r0; s0_addr = a0; s0_wen = a0[4]; s0_strb = a0[11:4]; s0_wdata = ~a0;
    s1_req = r1; s1_addr = a1; s1_wen = a1[4]; s1_strb = a1[11:4]; s1_wdata = a1 ^ 64'h5a5a;
    m_gnt = g; m_err = e; m_rdata = d;
  endtask

  initial begin
    lock = -1;
    last = 1;
    g_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge g_clk);

    // Reset held with traffic present: nothing reaches either side.
    drive(1, 64'h40, 1, 64'h80, 1, 1, 64'h1234);
    step("rst");
    chk("rst_m_req", obs_mreq, 1'b0);
    chk("rst_s0_gnt", obs_g0, 1'b0);

    // Release with both requesting and m_gnt high: port 0 then port 1.
    g_reset = 1'b0;
    step("rr0");
    chk("rel_c0_s0_gnt", obs_g0, 1'b1);
    drive(0, 64'h40, 1, 64'h80, 1, 0, 64'h1);
    step("rr1");
    chk("rel_c1_s1_gnt", obs_g1, 1'b1);
    drive(1, 64'h44, 1, 64'h84, 1, 0, 64'h2);
    step("rr2");
    chk("rel_c2_s0_gnt", obs_g0, 1'b1);

    // s0 held for 3 waiting cycles while s1 joins; s1 served afterwards.
    drive(1, 64'h1000, 0, 64'h2000, 0, 1, 64'h9);
    step("lk0");
    chk("lock_c0_addr", obs_maddr, 64'h1000);
    s1_req = 1'b1;
    step("lk1");
    chk("lock_c1_addr", obs_maddr, 64'h1000);
    step("lk2");
    chk("lock_c2_addr", obs_maddr, 64'h1000);
    m_gnt = 1'b1; m_err = 1'b0;
    step("lk3");
    chk("lock_c3_addr", obs_maddr, 64'h1000);
    chk("lock_c3_s0_gnt", obs_g0, 1'b1);
    s0_req = 1'b0;
    step("lk4");
    chk("lock_c4_s1_gnt", obs_g1, 1'b1);

    // Continuous requests on both ports alternate 0,1,0,1...
    drive(1, 64'h300, 1, 64'h400, 1, 0, 64'h77);
    for (int i = 0; i < 8; i++) begin
      step("alt");
      chk("alt_s0_gnt", obs_g0, (i % 2) == 0);
      chk("alt_s1_gnt", obs_g1, (i % 2) == 1);
    end

    // Error read on port 1.
    drive(0, 64'h0, 1, 64'h500, 0, 1, 64'hBEEF);
    s1_wen = 1'b0;
    step("er0");
    m_gnt = 1'b1; m_err = 1'b1; m_rdata = 64'hDEAD;
    step("er1");
    chk("err_s1_gnt", obs_g1, 1'b1);
    chk("err_s1_err", obs_e1, 1'b1);
    chk("err_s1_rdata", obs_r1, 64'hDEAD);
    chk("err_s0_gnt", obs_g0, 1'b0);
    chk("err_s0_err", obs_e0, 1'b0);

    // Asynchronous reset while port 1 owns with a grant pending.
    drive(0, 64'h600, 1, 64'h700, 0, 0, 64'h0);
    step("ar0");
    s0_req = 1'b1;
    step("ar1");
    g_reset = 1'b1; m_gnt = 1'b1;
    step("ar2");
    chk("arst_m_req", obs_mreq, 1'b0);
    g_reset = 1'b0;
    step("ar3");
    chk("arst_tie_s0", obs_g0, 1'b1);

    // Owner abort followed by a stray grant; lsb must stay at 1.
    drive(0, 64'h0, 1, 64'h800, 1, 0, 64'h3);
    step("ab0");
    drive(1, 64'h900, 0, 64'h0, 0, 0, 64'h0);
    step("ab1");
    drive(0, 64'h900, 0, 64'h0, 1, 1, 64'h4);
    step("ab2");
    chk("abort_m_req", obs_mreq, 1'b0);
    chk("abort_no_gnt", obs_g0 | obs_g1, 1'b0);
    drive(1, 64'hA00, 1, 64'hB00, 1, 0, 64'h5);
    step("ab3");
    chk("abort_tie_s0", obs_g0, 1'b1);

    // Randomized traffic obeying the hold-until-grant protocol, with
    // occasional withdrawals and reset pulses.
    e_g0 = 1'b1; e_g1 = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      g_reset = ($urandom_range(0, 249) == 0);
      if (s0_req && !e_g0) begin
        if ($urandom_range(0, 19) == 0) s0_req = 1'b0;
      end else begin
        s0_req = $urandom_range(0, 1);
        s0_addr = {$urandom, $urandom}; s0_wen = $urandom_range(0, 1);
        s0_strb = 8'($urandom); s0_wdata = {$urandom, $urandom};
      end
      if (s1_req && !e_g1) begin
        if ($urandom_range(0, 19) == 0) s1_req = 1'b0;
      end else begin
        s1_req = $urandom_range(0, 1);
        s1_addr = {$urandom, $urandom}; s1_wen = $urandom_range(0, 1);
        s1_strb = 8'($urandom); s1_wdata = {$urandom, $urandom};
      end
      m_gnt = ($urandom_range(0, 2) != 0);
      m_err = $urandom_range(0, 1);
      m_rdata = {$urandom, $urandom};
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb_2to1.md
MEM_ARB_2TO1 -- requirements
Module: mem_arb_2to1

Interface
REQ-001 MEM_ADDR_W, 64, address width.
REQ-002 MEM_STRB_W, 8, write strobe width.
REQ-003 MEM_DATA_W, 64, data width.
REQ-004 g_clk  in  1  sole clock, all state on rising edge.
REQ-005 g_reset  in  1  asynchronous, active-high reset.
REQ-006 s0_req  in  1  port 0 (instruction side) request.
REQ-007 s0_addr  in  MEM_ADDR_W  port 0 address.
REQ-008 s0_wen  in  1  port 0 write enable.
REQ-009 s0_strb  in  MEM_STRB_W  port 0 write strobe.
REQ-010 s0_wdata  in  MEM_DATA_W  port 0 write data.
REQ-011 s0_gnt  out  1  port 0 response valid / completion.
REQ-012 s0_err  out  1  port 0 response error.
REQ-013 s0_rdata  out  MEM_DATA_W  port 0 read data.
REQ-014 s1_req, s1_addr, s1_wen, s1_strb, s1_wdata, s1_gnt, s1_err, s1_rdata SHALL mirror REQ-006..REQ-013 for port 1 (data side).
REQ-015 m_req  out  1  downstream request.
REQ-016 m_addr  out  MEM_ADDR_W  downstream address.
REQ-017 m_wen  out  1  downstream write enable.
REQ-018 m_strb  out  MEM_STRB_W  downstream strobe.
REQ-019 m_wdata  out  MEM_DATA_W  downstream write data.
REQ-020 m_gnt  in  1  downstream response valid.
REQ-021 m_err  in  1  downstream response error.
REQ-022 m_rdata  in  MEM_DATA_W  downstream read data.

Function
REQ-023 Protocol on every port: requestor holds req and payload stable until gnt; transaction completes in the cycle req && gnt; gnt may arrive same cycle as req.
REQ-024 State: owner FSM {IDLE, OWN0, OWN1} plus last-served bit lsb; lsb records port that last completed.
REQ-025 IDLE, one port requesting: that port selected combinationally; no added latency.
REQ-026 IDLE, both requesting: port != lsb selected (round-robin).
REQ-027 Selected port's req/addr/wen/strb/wdata SHALL drive m_* in the same cycle; non-selected payload never reaches m_*.
REQ-028 IDLE, selected req and m_gnt=0: next state OWN<sel>; ownership locked, other port ignored until release.
REQ-029 OWNn: m_* driven from port n regardless of other port's req.
REQ-030 Completion (owner req && m_gnt): sN_gnt=1, sN_err=m_err, sN_rdata=m_rdata for owner; lsb<=n; next state IDLE.
REQ-031 Non-owner sX_gnt and sX_err SHALL be 0 in every cycle; sX_rdata SHALL be 0 when not granted.
REQ-032 Back-to-back: after completion, IDLE arbitration occurs the next cycle; one transaction per cycle maximum.
REQ-033 Abort: owner drops req in OWNn without m_gnt -> m_req=0, return to IDLE next cycle, lsb unchanged.
REQ-034 m_gnt while m_req=0 SHALL be ignored; no sX_gnt.
REQ-035 m_err without m_gnt SHALL not propagate.

Reset
REQ-036 g_reset asserted: state IDLE, lsb=1 (port 0 wins first tie), asynchronously, mid-transaction included.
REQ-037 During reset all sX_gnt=0, sX_err=0, sX_rdata=0, m_req=0; m_addr/m_wen/m_strb/m_wdata=0.
REQ-038 First edge after deassertion performs normal IDLE arbitration.

Verification
REQ-039 Reset release, both req, m_gnt=1 same cycle -> s0_gnt=1 cycle 0, s1_gnt=1 cycle 1, lsb ends at 1.
REQ-040 s0 req addr=0x1000, m_gnt delayed 3 cycles; s1 req raised in cycle 1 -> m_addr=0x1000 for all 4 cycles, s1 served cycle 4.
REQ-041 Both ports continuously request, m_gnt always 1 -> grants alternate 0,1,0,1 over 8 cycles.
REQ-042 s1 read completes with m_err=1, m_rdata=0xDEAD -> s1_gnt=1, s1_err=1, s1_rdata=0xDEAD; s0_gnt=0, s0_err=0.
REQ-043 g_reset pulsed during OWN1 with m_gnt pending -> m_req=0 immediately, state IDLE, next tie won by port 0.
REQ-044 Owner abort in OWN0 then stray m_gnt=1 -> no sX_gnt, lsb unchanged.
